// File: rtl/enabled_register_bank_pkg.sv
// Shared sizing constants and the address type for the eight-entry register bank.
package enabled_register_bank_pkg;

   localparam int NUM_ENTRIES = 8;
   localparam int ADDR_W      = 3;
   localparam int DEF_WIDTH   = 32;

   typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/enabled_register_bank_mux8to1_b32.sv
// Eight-way word selector used for each read port of the register bank.
module mux8to1_b32 #(
   parameter int WIDTH = 32
) (
   input  logic             S2,
   input  logic             S1,
   input  logic             S0,
   input  logic [WIDTH-1:0] I7,
   input  logic [WIDTH-1:0] I6,
   input  logic [WIDTH-1:0] I5,
   input  logic [WIDTH-1:0] I4,
   input  logic [WIDTH-1:0] I3,
   input  logic [WIDTH-1:0] I2,
   input  logic [WIDTH-1:0] I1,
   input  logic [WIDTH-1:0] I0,
   output logic [WIDTH-1:0] Y
);

   always_comb begin
      Y = I0;
      case ({S2, S1, S0})
         3'd0: Y = I0;
         3'd1: Y = I1;
         3'd2: Y = I2;
         3'd3: Y = I3;
         3'd4: Y = I4;
         3'd5: Y = I5;
         3'd6: Y = I6;
         3'd7: Y = I7;
         default: Y = I0;
      endcase
   end

endmodule

// File: rtl/enabled_register_bank.sv
// Eight-entry register bank, one write port and two combinational read ports.
// Optional falling-edge trace monitor compiled in with ENABLED_REGISTER_TRACE_EN.
module enabled_register_bank
   import enabled_register_bank_pkg::*;
#(
   parameter int               WIDTH       = DEF_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN,
   input  addr_t            WA,
   input  logic [WIDTH-1:0] D,
   input  addr_t            RA1,
   input  addr_t            RA2,
   output logic [WIDTH-1:0] Q1,
   output logic [WIDTH-1:0] Q2
);

   logic [WIDTH-1:0]       entry [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0] we;

   // One-hot write decode; all zero when EN is low.
   always_comb begin
      we = '0;
      if (EN) we[WA] = 1'b1;
   end

   // Reset wins over a same-edge write.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int k = 0; k < NUM_ENTRIES; k++) entry[k] <= RESET_VALUE;
      end else begin
         for (int k = 0; k < NUM_ENTRIES; k++)
            if (we[k]) entry[k] <= D;
      end
   end

   mux8to1_b32 #(.WIDTH(WIDTH)) u_rd1 (
      .S2(RA1[2]), .S1(RA1[1]), .S0(RA1[0]),
      .I7(entry[7]), .I6(entry[6]), .I5(entry[5]), .I4(entry[4]),
      .I3(entry[3]), .I2(entry[2]), .I1(entry[1]), .I0(entry[0]),
      .Y(Q1)
   );

   mux8to1_b32 #(.WIDTH(WIDTH)) u_rd2 (
      .S2(RA2[2]), .S1(RA2[1]), .S0(RA2[0]),
      .I7(entry[7]), .I6(entry[6]), .I5(entry[5]), .I4(entry[4]),
      .I3(entry[3]), .I2(entry[2]), .I1(entry[1]), .I0(entry[0]),
      .Y(Q2)
   );

`ifdef ENABLED_REGISTER_TRACE_EN
   // Observation only; reads state, never drives it.
   always @(negedge CLK) begin
      for (int k = 0; k < NUM_ENTRIES; k++)
         $display("entry[%0d] = %h", k, entry[k]);
      $display("entry[7] dec=%0d bin=%b", entry[7], entry[7]);
   end
`else
`endif

endmodule

// File: tb/tb_enabled_register_bank.sv
// Randomized and directed bench for enabled_register_bank against an array model.
module tb_enabled_register_bank;

   logic        CLK = 1'b0;
   logic        RST, EN;
   logic [2:0]  WA, RA1, RA2;
   logic [31:0] D, Q1, Q2;

   logic [31:0] model [8];
   int          n_tests = 0;
   int          n_fail  = 0;

   enabled_register_bank dut (
      .CLK(CLK), .RST(RST), .EN(EN), .WA(WA), .D(D),
      .RA1(RA1), .RA2(RA2), .Q1(Q1), .Q2(Q2)
   );

   always #10 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Clock one edge; model applies the storage rule to the inputs held across it.
   task automatic tick();
      @(posedge CLK);
      if (RST) begin
         for (int i = 0; i < 8; i++) model[i] = 32'h0;
      end else if (EN) begin
         model[WA] = D;
      end
      #1;
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < 8; i++) begin
         RA1 = 3'(i);
         RA2 = 3'(7 - i);
         #1;
         chk({tag, "_q1"}, Q1, model[i]);
         chk({tag, "_q2"}, Q2, model[7 - i]);
      end
   endtask

   task automatic write(input logic [2:0] a, input logic [31:0] v);
      RST = 1'b0; EN = 1'b1; WA = a; D = v;
      tick();
      EN = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 8; i++) model[i] = 32'hx;
      RST = 1'b1; EN = 1'b0; WA = '0; D = '0; RA1 = '0; RA2 = '0;
      #1;
      tick();
      RST = 1'b0;
      check_all("reset");

      for (int k = 0; k < 8; k++) begin
         write(3'(k), 32'h1111_1111 * k);
         RA1 = 3'(k);
         #1;
         chk("sweep_q1", Q1, 32'h1111_1111 * k);
      end
      check_all("sweep_all");

      EN = 1'b0; WA = 3'd3; D = 32'hDEAD_BEEF;
      tick();
      tick();
      RA1 = 3'd3;
      #1;
      chk("disabled_write", Q1, 32'h3333_3333);

      write(3'd7, 32'h0000_0005);
      EN = 1'b1; WA = 3'd7; D = 32'hFFFF_FFFF; RA1 = 3'd7;
      #1;
      chk("rdw_before", Q1, 32'h0000_0005);
      tick();
      EN = 1'b0;
      #1;
      chk("rdw_after", Q1, 32'hFFFF_FFFF);

      RST = 1'b1; EN = 1'b1; WA = 3'd2; D = 32'hA5A5_A5A5;
      tick();
      RST = 1'b0; EN = 1'b0; RA1 = 3'd2;
      #1;
      chk("rst_vs_write", Q1, 32'h0);
      check_all("rst_mid");

      write(3'd1, 32'h1234_5678);
      write(3'd6, 32'hCAFE_F00D);
      RA1 = 3'd1; RA2 = 3'd6;
      #1;
      chk("dual_q1", Q1, 32'h1234_5678);
      chk("dual_q2", Q2, 32'hCAFE_F00D);
      RA2 = 3'd1;
      #1;
      chk("same_addr", Q2, Q1 === 32'h1234_5678 ? Q1 : 32'h1234_5678);

      for (int n = 0; n < 400; n++) begin
         RST = ($urandom_range(0, 39) == 0);
         EN  = $urandom_range(0, 1);
         WA  = 3'($urandom_range(0, 7));
         D   = $urandom;
         RA1 = 3'($urandom_range(0, 7));
         RA2 = 3'($urandom_range(0, 7));
         #1;
         chk("rand_q1", Q1, model[RA1]);
         chk("rand_q2", Q2, model[RA2]);
         tick();
      end
      RST = 1'b0; EN = 1'b0;
      check_all("final");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
